// File: rtl/note_scroller_if.sv
// Signal bundle between the note scroller, its chart ROM, the strum input and the renderer.
// master: host/bench side; slave: the note_scroller itself.
interface note_scroller_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned ROWS   = 21,
  parameter int unsigned ADDR_W = 8
);
  logic                    start;
  logic                    pause;
  logic [ADDR_W-1:0]       rom_addr;
  logic [LANES-1:0]        rom_data;
  logic                    hit_strobe;
  logic [LANES-1:0]        hit_lanes;
  logic [ROWS*LANES-1:0]   window;
  logic                    hit;
  logic                    miss;
  logic [15:0]             score;
  logic                    busy;
  logic                    done;

  modport master (
    output start, pause, rom_data, hit_strobe, hit_lanes,
    input  rom_addr, window, hit, miss, score, busy, done
  );

  modport slave (
    input  start, pause, rom_data, hit_strobe, hit_lanes,
    output rom_addr, window, hit, miss, score, busy, done
  );
endinterface

// File: rtl/note_scroller.sv
// Note-chart sequencer: scrolls chart rows from a synchronous ROM through an on-screen window,
// judges strums against the bottom (hit) row and keeps a saturating score.
module note_scroller #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned ROWS        = 21,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned CHART_LEN   = 256,
  parameter int unsigned STEP_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            reset,
  note_scroller_if.slave  bus
);

  localparam int unsigned CntW  = $clog2(STEP_CYCLES);
  localparam int unsigned StepW = $clog2(CHART_LEN + ROWS + 1);
  localparam int unsigned WinW  = ROWS * LANES;

  localparam logic [CntW-1:0]  CntReload = CntW'(STEP_CYCLES - 1);
  localparam logic [StepW-1:0] LastStep  = StepW'(CHART_LEN + ROWS - 1);
  localparam logic [StepW-1:0] ChartEnd  = StepW'(CHART_LEN);

  typedef enum logic [1:0] {StIdle, StPrime, StPlay} state_e;

  state_e            state_q, state_d;
  logic [WinW-1:0]   window_q, window_d;
  logic [LANES-1:0]  next_row_q, next_row_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [StepW-1:0]  steps_q, steps_d;
  logic              load_q, load_d;
  logic              hit_q, hit_d;
  logic              miss_q, miss_d;
  logic [15:0]       score_q, score_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [LANES-1:0]  hit_row;
  logic [LANES-1:0]  row0;
  logic              strum_ok;
  logic              step_now;

  always_comb begin
    state_d    = state_q;
    window_d   = window_q;
    next_row_d = next_row_q;
    rom_addr_d = rom_addr_q;
    cnt_d      = cnt_q;
    steps_d    = steps_q;
    load_d     = 1'b0;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    score_d    = score_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    strum_ok   = 1'b0;
    step_now   = 1'b0;
    hit_row    = window_q[(ROWS-1)*LANES +: LANES];
    row0       = (steps_q < ChartEnd) ? next_row_q : '0;

    // ROM word for the address presented during the step cycle arrives one cycle later
    if (load_q) next_row_d = bus.rom_data;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StPrime;
          window_d   = '0;
          score_d    = '0;
          cnt_d      = '0;
          steps_d    = '0;
          rom_addr_d = '0;
          busy_d     = 1'b1;
        end
      end
      StPrime: begin
        state_d    = StPlay;
        next_row_d = bus.rom_data;
        rom_addr_d = ADDR_W'(1);
        cnt_d      = CntReload;
      end
      StPlay: begin
        strum_ok = !bus.pause && bus.hit_strobe && (hit_row != '0) && (bus.hit_lanes == hit_row);
        step_now = !bus.pause && (cnt_q == '0);
        if (!bus.pause) cnt_d = step_now ? CntReload : cnt_q - CntW'(1);
        if (strum_ok) begin
          hit_d = 1'b1;
          window_d[(ROWS-1)*LANES +: LANES] = '0;
          if (score_q != '1) score_d = score_q + 16'd1;
        end
        if (step_now) begin
          window_d   = {window_q[WinW-LANES-1:0], row0};
          miss_d     = (hit_row != '0) && !strum_ok;
          rom_addr_d = rom_addr_q + ADDR_W'(1);
          load_d     = 1'b1;
          steps_d    = steps_q + StepW'(1);
          if (steps_q == LastStep) begin
            // Park at word 0 so the ROM already presents it when the next start is sampled
            state_d    = StIdle;
            rom_addr_d = '0;
            load_d     = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      window_q   <= '0;
      next_row_q <= '0;
      rom_addr_q <= '0;
      cnt_q      <= '0;
      steps_q    <= '0;
      load_q     <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      score_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      next_row_q <= next_row_d;
      rom_addr_q <= rom_addr_d;
      cnt_q      <= cnt_d;
      steps_q    <= steps_d;
      load_q     <= load_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      score_q    <= score_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.window   = window_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.hit      = hit_q;
  assign bus.miss     = miss_q;
  assign bus.score    = score_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_note_scroller.sv
// Bench for note_scroller: directed songs plus randomized play, checked every cycle against a
// row-array reference model that reads the chart directly instead of through the ROM pipeline.
module tb_note_scroller;

  localparam int unsigned LANES       = 4;
  localparam int unsigned ROWS        = 4;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned CHART_LEN   = 3;
  localparam int unsigned STEP_CYCLES = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  note_scroller_if #(.LANES(LANES), .ROWS(ROWS), .ADDR_W(ADDR_W)) bus();

  note_scroller #(
    .LANES      (LANES),
    .ROWS       (ROWS),
    .ADDR_W     (ADDR_W),
    .CHART_LEN  (CHART_LEN),
    .STEP_CYCLES(STEP_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  // Synchronous chart ROM: data for an address is presented the cycle after it.
  logic [LANES-1:0] rom [16];
  logic [LANES-1:0] rom_q = '0;
  always @(posedge clk) rom_q <= rom[bus.rom_addr];
  assign bus.rom_data = rom_q;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  int               m_state;  // 0 idle, 1 prime, 2 play
  int               m_left;   // unpaused play cycles remaining until the next step
  int               m_steps;
  logic [LANES-1:0] m_rows [ROWS];
  logic [ADDR_W-1:0] m_addr;
  logic [15:0]      m_score;
  logic             m_hit, m_miss, m_done, m_busy;

  int obs_hits, obs_misses, obs_done, obs_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ROWS*LANES-1:0] pack_rows();
    logic [ROWS*LANES-1:0] w;
    for (int r = 0; r < ROWS; r++) w[r*LANES +: LANES] = m_rows[r];
    return w;
  endfunction

  task automatic model_reset();
    m_state = 0; m_left = 0; m_steps = 0; m_addr = '0; m_score = '0;
    m_hit = 0; m_miss = 0; m_done = 0; m_busy = 0;
    for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
  endtask

  task automatic model_tick(input logic s, input logic p, input logic hs,
                            input logic [LANES-1:0] hl);
    logic [LANES-1:0] bottom;
    logic matched;
    m_hit = 0; m_miss = 0; m_done = 0;
    case (m_state)
      0: if (s) begin
        m_state = 1; m_score = '0; m_addr = '0; m_busy = 1; m_steps = 0;
        for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
      end
      1: begin
        m_state = 2; m_addr = ADDR_W'(1); m_left = STEP_CYCLES;
      end
      default: if (!p) begin
        bottom  = m_rows[ROWS-1];
        matched = hs && (bottom != '0) && (hl == bottom);
        if (matched) begin
          m_hit = 1;
          if (m_score != 16'hFFFF) m_score = m_score + 16'd1;
          m_rows[ROWS-1] = '0;
        end
        if (m_left == 1) begin
          m_miss = (bottom != '0) && !matched;
          for (int r = ROWS - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
          m_rows[0] = (m_steps < CHART_LEN) ? rom[m_steps] : '0;
          m_steps++;
          m_addr = m_addr + ADDR_W'(1);
          m_left = STEP_CYCLES;
          if (m_steps == CHART_LEN + ROWS) begin
            m_state = 0; m_busy = 0; m_done = 1; m_addr = '0;
          end
        end else begin
          m_left--;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("window",   bus.window,   pack_rows());
    check("rom_addr", bus.rom_addr, m_addr);
    check("hit",      bus.hit,      m_hit);
    check("miss",     bus.miss,     m_miss);
    check("score",    bus.score,    m_score);
    check("busy",     bus.busy,     m_busy);
    check("done",     bus.done,     m_done);
  endtask

  task automatic cycle(input logic s, input logic p, input logic hs, input logic [LANES-1:0] hl);
    bus.start = s; bus.pause = p; bus.hit_strobe = hs; bus.hit_lanes = hl;
    model_tick(s, p, hs, hl);
    @(posedge clk);
    #1;
    compare_all();
    obs_hits   += int'(bus.hit);
    obs_misses += int'(bus.miss);
    obs_done   += int'(bus.done);
    obs_busy   += int'(bus.busy);
  endtask

  // mode 0: no strums (+ a start while busy), 1: correct strum, 2: wrong strum,
  // 3: strum on the final step, 4: 10-cycle pause with ignored strums, 5: random
  task automatic run_song(input int mode, input int exp_hits, input int exp_misses,
                          input int exp_busy);
    logic s, p, hs;
    logic [LANES-1:0] hl;
    int guard = 0;
    int pause_left = 0;
    bit paused_once = 0;
    obs_hits = 0; obs_misses = 0; obs_done = 0; obs_busy = 0;
    cycle(1'b1, 1'b0, 1'b0, '0);
    while (m_state != 0 && guard < 400) begin
      s = 0; p = 0; hs = 0; hl = '0;
      case (mode)
        0: if (m_state == 2 && m_steps == 3 && m_left == 2) s = 1;
        1: if (m_state == 2 && m_steps == 4 && m_left == 2) begin hs = 1; hl = 4'b1000; end
        2: if (m_state == 2 && m_steps == 4 && m_left == 2) begin hs = 1; hl = 4'b0001; end
        3: if (m_state == 2 && m_steps == 6 && m_left == 1) begin hs = 1; hl = 4'b0011; end
        4: begin
          if (!paused_once && m_state == 2 && m_steps == 4 && m_left == 3) begin
            pause_left = 10; paused_once = 1;
          end
          if (pause_left > 0) begin p = 1; hs = 1; hl = 4'b1000; pause_left--; end
        end
        default: begin
          s  = ($urandom_range(0, 9) == 0);
          p  = ($urandom_range(0, 4) == 0);
          hs = ($urandom_range(0, 3) == 0);
          hl = ($urandom_range(0, 1) == 1) ? m_rows[ROWS-1] : LANES'($urandom);
        end
      endcase
      cycle(s, p, hs, hl);
      guard++;
    end
    check("done_pulses", obs_done, 1);
    check("window_end", bus.window, '0);
    if (exp_hits >= 0) begin
      check("song_hits", obs_hits, exp_hits);
      check("song_misses", obs_misses, exp_misses);
      check("song_score", bus.score, exp_hits);
      check("busy_cycles", obs_busy, exp_busy);
    end
  endtask

  task automatic reset_mid();
    cycle(1'b1, 1'b0, 1'b0, '0);
    repeat (9) cycle(1'b0, 1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_window", bus.window, '0);
    check("rst_addr",   bus.rom_addr, '0);
    check("rst_score",  bus.score, '0);
    check("rst_busy",   bus.busy, 0);
    check("rst_hitmiss", {bus.hit, bus.miss, bus.done}, 0);
    model_reset();
    obs_done = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      compare_all();
      obs_done += int'(bus.done);
    end
    check("rst_no_done", obs_done, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      if (i == 0)      rom[i] = 4'b1000;
      else if (i == 1) rom[i] = 4'b0000;
      else if (i == 2) rom[i] = 4'b0011;
      else             rom[i] = LANES'($urandom_range(1, 15));
    end
    bus.start = 0; bus.pause = 0; bus.hit_strobe = 0; bus.hit_lanes = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    cycle(1'b0, 1'b1, 1'b1, 4'b1000);
    cycle(1'b0, 1'b0, 1'b1, 4'b1111);

    run_song(0, 0, 2, 29);
    run_song(1, 1, 1, 29);
    run_song(2, 0, 2, 29);
    run_song(3, 1, 1, 29);
    run_song(4, 0, 2, 39);
    reset_mid();
    run_song(0, 0, 2, 29);
    for (int k = 0; k < 8; k++) begin
      run_song(5, -1, -1, -1);
      repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 1'b1, LANES'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
